// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Fetch sequencer for the combinational instruction ROM. Owns the PC,
//   presents it on imem_addr, captures returned words into a 2-entry queue
//   and hands (instr, pc) pairs to decode over a valid/ready handshake.
//   Redirects from execute flush the queue; illegal fetch addresses
//   (misaligned or outside the ROM window) raise a sticky fault.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   en               - fetch enable (0 = hold PC, no new fetches)
//   redirect_valid   - taken branch/jump/trap, target on redirect_pc
//   imem_addr        - ROM address (always the PC register)
//   imem_rdata       - ROM read data for imem_addr
//   out_valid/ready  - handshake to decode; out_instr/out_pc = queue head
//   fault/fault_addr - sticky fetch fault flag and offending address
//   issued_cnt       - saturating count of instructions popped by decode
module imem_fetch_ctrl #(
  parameter int                 A_WIDTH  = 32,
  parameter int                 I_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = 32'hBFC00000,
  parameter logic [A_WIDTH-1:0] ROM_BASE = 32'hBFC00000,
  parameter logic [A_WIDTH-1:0] ROM_LAST = 32'hBFC00FFC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic [I_WIDTH-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] out_instr,
  output logic [A_WIDTH-1:0] out_pc,
  output logic               fault,
  output logic [A_WIDTH-1:0] fault_addr,
  output logic [15:0]        issued_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t             state, next_state;
  logic [A_WIDTH-1:0] pc;
  logic [1:0]         count;
  logic               head, tail;
  logic [I_WIDTH-1:0] instr_q [2];
  logic [A_WIDTH-1:0] pc_q    [2];

  logic pop, push, pc_good, redir_good, redir_act, seq_fault;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = instr_q[head];
  assign out_pc    = pc_q[head];

  // Handshake, address legality and the fetch decision. A full queue can
  // still accept a word when the head leaves in the same cycle.
  always_comb begin
    pop        = out_valid && out_ready;
    pc_good    = (pc[1:0] == 2'b00) && (pc >= ROM_BASE) && (pc <= ROM_LAST);
    redir_good = (redirect_pc[1:0] == 2'b00) && (redirect_pc >= ROM_BASE) &&
                 (redirect_pc <= ROM_LAST);
    redir_act  = redirect_valid && (state != IDLE);
    push       = (state == RUN) && en && !redirect_valid && pc_good &&
                 ((count < 2'd2) || pop);
    seq_fault  = (state == RUN) && !redirect_valid && !pc_good;
  end

  // Next-state logic; a redirect decides RUN vs FAULT purely on its target.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (en) next_state = RUN;
      RUN: begin
        if (redir_act)      next_state = redir_good ? RUN : FAULT;
        else if (seq_fault) next_state = FAULT;
      end
      FAULT: if (redir_act && redir_good) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // PC, queue, fault and counter registers. The redirect branch flushes the
  // queue by zeroing the count and realigning both pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      count      <= 2'd0;
      head       <= 1'b0;
      tail       <= 1'b0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
      issued_cnt <= 16'd0;
    end else begin
      state <= next_state;

      // A pop in the redirect cycle still counts as delivered to decode.
      if (pop && (issued_cnt != 16'hFFFF))
        issued_cnt <= issued_cnt + 16'd1;

      if (redir_act) begin
        pc    <= redirect_pc;
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
        fault <= !redir_good;
        if (!redir_good)
          fault_addr <= redirect_pc;
      end else begin
        if (push) begin
          instr_q[tail] <= imem_rdata;
          pc_q[tail]    <= pc;
          tail          <= ~tail;
          pc            <= pc + A_WIDTH'(4);
        end
        if (pop)
          head <= ~head;
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
        if (seq_fault) begin
          fault      <= 1'b1;
          fault_addr <= pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
//   Directed bench for imem_fetch_ctrl. A ROM model returns a word derived
//   from the low 12 address bits so every fetched word is distinguishable.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst, en, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic        out_valid, fault;
  logic [31:0] out_instr, out_pc, fault_addr;
  logic [15:0] issued_cnt;

  int tests = 0;
  int fails = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fault_addr(fault_addr), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h5A000000 | (a & 32'h00000FFF);
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  // Queue occupancy must never exceed two entries.
  always @(negedge clk) begin
    if (!rst && (dut.count > 2'd2)) begin
      fails++;
      $display("[TB] FAIL queue_bound: count %0d exceeds 2", dut.count);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_instr: got %h want 0", out_instr); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc: got %h want 0", out_pc); end
    tests++; if (fault !== 1'b0 || fault_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_fault: got %0b/%h want 0/0", fault, fault_addr); end
    tests++; if (issued_cnt !== 16'h0) begin fails++; $display("[TB] FAIL reset_issued: got %h want 0", issued_cnt); end
    tests++; if (imem_addr !== BASE) begin fails++; $display("[TB] FAIL reset_addr: got %h want %h", imem_addr, BASE); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    en = 1'b1; out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_idle_bubble: got %0b want 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      a = BASE + 32'(4 * i);
      tests++; if (out_valid !== 1'b1 || out_instr !== rom_word(a) || out_pc !== a) begin fails++; $display("[TB] FAIL stream_pair%0d: got %0b %h %h want 1 %h %h", i, out_valid, out_instr, out_pc, rom_word(a), a); end
      tests++; if (issued_cnt !== 16'(i)) begin fails++; $display("[TB] FAIL stream_issued%0d: got %0d want %0d", i, issued_cnt, i); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests++; if (dut.count !== 2'd2) begin fails++; $display("[TB] FAIL stall_count: got %0d want 2", dut.count); end
    tests++; if (imem_addr !== BASE + 32'd20) begin fails++; $display("[TB] FAIL stall_pc: got %h want %h", imem_addr, BASE + 32'd20); end
    tests++; if (out_valid !== 1'b1 || out_pc !== BASE + 32'd12 || issued_cnt !== 16'd3) begin fails++; $display("[TB] FAIL stall_head: got %0b %h %0d want 1 %h 3", out_valid, out_pc, issued_cnt, BASE + 32'd12); end
    out_ready = 1'b1;
    for (int i = 4; i < 7; i++) begin
      tick();
      a = BASE + 32'(4 * i);
      tests++; if (out_instr !== rom_word(a) || out_pc !== a || issued_cnt !== 16'(i)) begin fails++; $display("[TB] FAIL release_pair%0d: got %h %h %0d want %h %h %0d", i, out_instr, out_pc, issued_cnt, rom_word(a), a, i); end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] a;
    a = BASE + 32'h100;
    tests++; if (dut.count !== 2'd2) begin fails++; $display("[TB] FAIL redirect_precount: got %0d want 2", dut.count); end
    redirect_valid = 1'b1; redirect_pc = a;
    tick();
    redirect_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || imem_addr !== a || issued_cnt !== 16'd7) begin fails++; $display("[TB] FAIL redirect_flush: got %0b %h %0d want 0 %h 7", out_valid, imem_addr, issued_cnt, a); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_instr !== rom_word(a) || out_pc !== a) begin fails++; $display("[TB] FAIL redirect_first: got %0b %h %h want 1 %h %h", out_valid, out_instr, out_pc, rom_word(a), a); end
    tick();
    tests++; if (out_pc !== a + 32'd4 || issued_cnt !== 16'd8) begin fails++; $display("[TB] FAIL redirect_second: got %h %0d want %h 8", out_pc, issued_cnt, a + 32'd4); end
  endtask

  task automatic test_bad_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'hBFC00102;
    tick();
    redirect_valid = 1'b0;
    tests++; if (fault !== 1'b1 || fault_addr !== 32'hBFC00102) begin fails++; $display("[TB] FAIL misalign_fault: got %0b %h want 1 bfc00102", fault, fault_addr); end
    tick(); tick();
    tests++; if (out_valid !== 1'b0 || imem_addr !== 32'hBFC00102) begin fails++; $display("[TB] FAIL misalign_hold: got %0b %h want 0 bfc00102", out_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tests++; if (fault !== 1'b1 || fault_addr !== 32'h0 || imem_addr !== 32'h0) begin fails++; $display("[TB] FAIL window_fault: got %0b %h %h want 1 0 0", fault, fault_addr, imem_addr); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL window_nopush: got %0b want 0", out_valid); end
    redirect_valid = 1'b1; redirect_pc = BASE;
    tick();
    redirect_valid = 1'b0;
    tests++; if (fault !== 1'b0 || fault_addr !== 32'h0 || imem_addr !== BASE) begin fails++; $display("[TB] FAIL recover_clear: got %0b %h %h want 0 0 %h", fault, fault_addr, imem_addr, BASE); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_instr !== rom_word(BASE) || out_pc !== BASE) begin fails++; $display("[TB] FAIL recover_fetch: got %0b %h %h want 1 %h %h", out_valid, out_instr, out_pc, rom_word(BASE), BASE); end
  endtask

  task automatic test_window_end();
    redirect_valid = 1'b1; redirect_pc = 32'hBFC00FF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'hBFC00FF8 || out_instr !== 32'h5A000FF8) begin fails++; $display("[TB] FAIL end_ff8: got %0b %h %h want 1 bfc00ff8 5a000ff8", out_valid, out_pc, out_instr); end
    tick();
    tests++; if (out_pc !== 32'hBFC00FFC || out_instr !== 32'h5A000FFC || imem_addr !== 32'hBFC01000) begin fails++; $display("[TB] FAIL end_ffc: got %h %h %h want bfc00ffc 5a000ffc bfc01000", out_pc, out_instr, imem_addr); end
    tests++; if (fault !== 1'b0) begin fails++; $display("[TB] FAIL end_early_fault: got %0b want 0", fault); end
    tick();
    tests++; if (fault !== 1'b1 || fault_addr !== 32'hBFC01000 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL end_fault: got %0b %h %0b want 1 bfc01000 0", fault, fault_addr, out_valid); end
    tick();
    tests++; if (imem_addr !== 32'hBFC01000 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL end_hold: got %h %0b want bfc01000 0", imem_addr, out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hBFC00FF8;
    tick();
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    tests++; if (dut.count !== 2'd2 || fault !== 1'b1) begin fails++; $display("[TB] FAIL mid_setup: got %0d %0b want 2 1", dut.count, fault); end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = BASE + 32'h40;
    tick();
    rst = 1'b0; en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hBFC00FF8;
    tests++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || fault !== 1'b0 || fault_addr !== 32'h0 || issued_cnt !== 16'h0 || imem_addr !== BASE) begin fails++; $display("[TB] FAIL mid_reset: got %0b %h %h %0b %h %h %h", out_valid, out_instr, out_pc, fault, fault_addr, issued_cnt, imem_addr); end
    tick();
    redirect_valid = 1'b0;
    tests++; if (imem_addr !== BASE || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_redirect_ignored: got %h %0b want %h 0", imem_addr, out_valid, BASE); end
  endtask

  task automatic test_saturate();
    force dut.issued_cnt = 16'hFFFE;
    #1;
    release dut.issued_cnt;
    en = 1'b1; out_ready = 1'b1;
    tick(); tick();
    tests++; if (issued_cnt !== 16'hFFFE || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL sat_preload: got %h %0b want fffe 1", issued_cnt, out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (issued_cnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL sat_pop%0d: got %h want ffff", i, issued_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_bad_redirect();
    test_window_end();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the pipelined CPU's combinational instruction ROM (byte-addressed, little-endian 32-bit reads, window 0xBFC00000–0xBFC00FFF).
- Owns the PC and drives the ROM address.
- Captures returned words into a 2-entry fetch queue, handing (instr, pc) pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects with a queue flush.
- Traps misaligned or out-of-window fetch addresses.

Parameters:
A_WIDTH, 32, address/PC width
I_WIDTH, 32, instruction width (4 ROM bytes)
RESET_PC, 32'hBFC00000, PC loaded on reset
ROM_BASE, 32'hBFC00000, lowest legal fetch address
ROM_LAST, 32'hBFC00FFC, highest legal word-aligned fetch address

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
en  in  1  fetch enable; 0 = hold PC, no new fetches
redirect_valid  in  1  taken branch/jump/trap from execute
redirect_pc  in  A_WIDTH  redirect target
imem_addr  out  A_WIDTH  ROM address, always = PC register
imem_rdata  in  I_WIDTH  ROM read data (combinational from imem_addr)
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  I_WIDTH  head instruction
out_pc  out  A_WIDTH  head PC
fault  out  1  fetch fault sticky flag
fault_addr  out  A_WIDTH  offending address
issued_cnt  out  16  instructions delivered (pops), saturating

Behaviour:
- Reset (rst=1 at edge, overrides everything including mid-redirect):
  - pc=RESET_PC; state=IDLE; queue count=0; both entries cleared to 0.
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_addr=0, issued_cnt=0.
- States: IDLE, RUN, FAULT.
  - IDLE -> RUN when en=1. No fetch occurs in the IDLE cycle; the first fetch is the cycle after.
  - RUN -> FAULT on a bad sequential PC or bad redirect target.
  - FAULT -> RUN only on a redirect with a good target.
- Address legality:
  - good = addr[1:0]==0 and ROM_BASE <= addr <= ROM_LAST (unsigned compare).
- pop = out_valid & out_ready. out_valid = (count!=0). out_instr/out_pc come from the head entry (registered, no combinational path from imem_rdata).
- fetch condition, in RUN: en=1, no redirect, pc good, and (count<2 or pop).
  - The word on imem_rdata is written at the tail with its pc; pc <= pc+4.
  - Zero-bubble: a fetch issued every cycle while decode pops every cycle sustains 1 instr/cycle with count==1.
- Simultaneous push+pop: count unchanged. Push+pop at count=2 is allowed.
- Bad sequential PC in RUN (e.g. pc=0xBFC01000 after ROM_LAST):
  - No push, pc holds, state->FAULT, fault=1, fault_addr=pc.
  - Queue continues draining.
- Redirect (any state except IDLE; highest priority after rst):
  - Queue flushed (count=0 next cycle). A same-cycle pop is still counted in issued_cnt, but its entry is discarded with the flush.
  - No push that cycle; pc <= redirect_pc.
  - If the target is bad: state->FAULT, fault=1, fault_addr=redirect_pc.
  - If good: state->RUN, fault cleared to 0, fault_addr holds its last value.
  - The first instruction from the target appears at out_valid two edges after the redirect edge (1-cycle refetch bubble).
- Redirect in IDLE is ignored.
- en=0 in RUN: no fetch and pc holds; the queue still drains and redirects are still honoured.
- FAULT:
  - No fetches; imem_addr = held pc.
  - Queue drains normally; fault stays 1 until a good redirect or rst.
- issued_cnt increments on each pop and saturates at 16'hFFFF (no wrap).
- Queue: 2-entry circular buffer with 1-bit head/tail pointers that wrap 1->0. Overflow and underflow are impossible by construction; the bench asserts count never exceeds 2.

Test Plan:
- Reset then en=1, out_ready=1, ROM words W0..W3 at 0xBFC00000.. -> out_valid first high 2 edges after en; pairs (W0,0xBFC00000),(W1,0xBFC00004)… one per cycle; issued_cnt increments every cycle.
- out_ready=0 for 5 cycles while running -> count stops at 2, pc=0xBFC00008 and stable; release -> W0,W1,W2 delivered in order with no loss or duplication.
- Redirect to 0xBFC00100 while queue holds 2 and out_ready=1 -> both entries flushed; next delivered pair (word@0x100, 0xBFC00100) after a 1-cycle bubble.
- Redirect to 0xBFC00102, then separately to 0x00000000 -> FAULT each time, fault=1, fault_addr=0xBFC00102 / 0x00000000, no further pushes; a good redirect to 0xBFC00000 clears fault and resumes.
- Start at pc=0xBFC00FF8 via redirect, run -> words @0xFF8 and 0xFFC delivered, then fault=1 with fault_addr=0xBFC01000; queue drains to empty.
- Assert rst mid-stream with count=2 and fault=1 -> next cycle all outputs at reset values, state IDLE, imem_addr=0xBFC00000; preload issued_cnt to 0xFFFE by forcing, then 3 pops -> value stays 0xFFFF.
